// File: rtl/sha256_compress.sv
// sha256_compress: iterative SHA-256 compression, one round per cycle over a W-word stream.
module sha256_rotr #(parameter int N = 1) (
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = {x[N-1:0], x[31:N]};
endmodule

module sha256_compress (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] hin,
  input  logic         w_valid,
  input  logic [31:0]  w_data,
  output logic         w_ready,
  output logic         busy,
  output logic         done,
  output logic [255:0] hout
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;
  localparam logic [2047:0] K_TAB = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  state_t state;
  logic [5:0] t;
  logic [31:0] a, b, c, d, e, f, g, h;
  logic [255:0] hs;
  logic [31:0] a2, a13, a22, e6, e11, e25;
  logic [31:0] s0, s1, ch, maj, k, t1, t2, na, ne;
  sha256_rotr #(2)  r2  (.x(a), .y(a2));
  sha256_rotr #(13) r13 (.x(a), .y(a13));
  sha256_rotr #(22) r22 (.x(a), .y(a22));
  sha256_rotr #(6)  r6  (.x(e), .y(e6));
  sha256_rotr #(11) r11 (.x(e), .y(e11));
  sha256_rotr #(25) r25 (.x(e), .y(e25));
  // K[0] sits in the top word, so round t lives at offset (63-t)*32 = {~t, 5'b0}
  always_comb begin
    s0 = a2 ^ a13 ^ a22;
    s1 = e6 ^ e11 ^ e25;
    ch = (e & f) ^ (~e & g);
    maj = (a & b) ^ (a & c) ^ (b & c);
    k = K_TAB[{~t, 5'b0} +: 32];
    t1 = h + s1 + ch + k + w_data;
    t2 = s0 + maj;
    na = t1 + t2;
    ne = d + t1;
  end
  // the digest is folded in on the last accept so done and hout rise together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      t <= '0;
      {a, b, c, d, e, f, g, h} <= '0;
      hs <= '0;
      hout <= '0;
      w_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          {a, b, c, d, e, f, g, h} <= hin;
          hs <= hin;
          t <= '0;
          state <= ROUND;
          busy <= 1'b1;
          w_ready <= 1'b1;
        end
        ROUND: if (w_valid) begin
          {a, b, c, d, e, f, g, h} <= {na, a, b, c, ne, e, f, g};
          t <= t + 6'd1;
          if (t == 6'd63) begin
            state <= FINAL;
            w_ready <= 1'b0;
            done <= 1'b1;
            hout <= {hs[255:224] + na, hs[223:192] + a, hs[191:160] + b, hs[159:128] + c,
                     hs[127:96] + ne, hs[95:64] + e, hs[63:32] + f, hs[31:0] + g};
          end
        end
        FINAL: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_compress.sv
// tb_sha256_compress: random/directed stimulus with a queued-digest scoreboard and reference model.
module tb_sha256_compress;
  logic clk = 1'b0;
  logic rst_n, start, w_valid, w_ready, busy, done;
  logic [255:0] hin, hout;
  logic [31:0] w_data;
  always #5 clk = ~clk;
  sha256_compress dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hin(hin), .w_valid(w_valid), .w_data(w_data),
    .w_ready(w_ready), .busy(busy), .done(done), .hout(hout)
  );
  localparam logic [255:0] IV  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  int checks = 0, errors = 0;
  int cyc = 0, start_cyc = 0, exp_lat = 65, done_cnt = 0, acc_cnt = 0;
  logic [255:0] expq [$];
  logic [31:0] wsch [64];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_sched(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) wsch[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(wsch[i-15], 7) ^ rotr(wsch[i-15], 18) ^ (wsch[i-15] >> 3);
      s1 = rotr(wsch[i-2], 17) ^ rotr(wsch[i-2], 19) ^ (wsch[i-2] >> 10);
      wsch[i] = wsch[i-16] + s0 + wsch[i-7] + s1;
    end
  endtask

  function automatic logic [255:0] ref_compress(input logic [255:0] hv);
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) v[i] = hv[255 - 32*i -: 32];
    for (int j = 0; j < 64; j++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[j] + wsch[j];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hv[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (w_valid && w_ready) acc_cnt <= acc_cnt + 1;
  end

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (expq.size() == 0) chk("spurious_done", hout, 256'd0 ^ ~hout);
      else begin
        chk("digest", hout, expq.pop_front());
        chk("latency", 256'(cyc - start_cyc + 1), 256'(exp_lat));
      end
    end
  end

  task automatic run_block(input logic [255:0] hv, input logic [255:0] exp, input int gap, input int mode);
    int idx, gaps, n, acc0;
    bit pulsed, probed;
    idx = 0; gaps = 0; n = 0; pulsed = 0; probed = 0;
    @(negedge clk);
    hin = hv; start = 1'b1; expq.push_back(exp); exp_lat = 65; acc0 = acc_cnt;
    @(negedge clk);
    start = 1'b0; start_cyc = cyc;
    while (idx < 64 && n < 1000) begin
      start = 1'b0;
      if (mode == 1 && idx == 1 && !probed) begin
        probed = 1;
        chk("round0_a", 256'(dut.a), 256'h5d6aebcd);
        chk("round0_e", 256'(dut.e), 256'hfa2a4622);
      end
      if (mode == 2 && idx == 10 && !pulsed) begin
        pulsed = 1; start = 1'b1; hin = ~hv;
      end
      if (mode == 3 && idx == 30) begin
        w_valid = 1'b0; rst_n = 1'b0;
        #1;
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_w_ready", 256'(w_ready), 256'd0);
        chk("rst_done", 256'(done), 256'd0);
        chk("rst_hout", hout, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expq.delete();
        return;
      end
      w_valid = ($urandom_range(99) >= gap);
      w_data = wsch[idx];
      if (w_valid && w_ready) idx++;
      else gaps++;
      exp_lat = 65 + gaps;
      @(negedge clk);
      n++;
    end
    start = 1'b0; w_valid = 1'b0; w_data = $urandom;
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout accepted=%0d want=64", idx);
      expq.delete();
    end
    chk("accepts", 256'(acc_cnt - acc0), 256'd64);
  endtask

  logic [511:0] blk_abc, blk1, blk2;
  logic [447:0] msg;
  logic [255:0] hv, e1;
  int exp_done = 0;

  initial begin
    rst_n = 1'b0; start = 1'b0; hin = '0; w_valid = 1'b0; w_data = '0;
    blk_abc = {24'h616263, 8'h80, 416'h0, 64'd24};
    msg = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    blk1 = {msg, 8'h80, 56'h0};
    blk2 = {448'h0, 64'd448};
    repeat (3) @(negedge clk);
    chk("reset_busy", 256'(busy), 256'd0);
    chk("reset_w_ready", 256'(w_ready), 256'd0);
    chk("reset_done", 256'(done), 256'd0);
    chk("reset_hout", hout, 256'd0);
    rst_n = 1'b1;
    build_sched(blk_abc);
    chk("sched_w0", 256'(wsch[0]), 256'h61626380);
    chk("sched_w15", 256'(wsch[15]), 256'h00000018);
    run_block(IV, ABC, 0, 1); exp_done++;
    run_block(IV, ABC, 30, 0); exp_done++;
    run_block(IV, ABC, 20, 2); exp_done++;
    run_block(IV, ABC, 0, 3);
    run_block(IV, ABC, 0, 0); exp_done++;
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 8; j++) hv[32*j +: 32] = $urandom;
      for (int j = 0; j < 64; j++) wsch[j] = $urandom;
      run_block(hv, ref_compress(hv), 25, 0); exp_done++;
    end
    build_sched(blk1);
    e1 = ref_compress(IV);
    run_block(IV, e1, 0, 0); exp_done++;
    build_sched(blk2);
    run_block(hout, TWO, 0, 0); exp_done++;
    repeat (5) @(negedge clk);
    chk("done_count", 256'(done_cnt), 256'(exp_done));
    chk("queue_empty", 256'(expq.size()), 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sha256_compress.md
# sha256_compress

Iterative SHA-256 compression engine: it performs the 64 rounds of one 512-bit block at one round per cycle. It sits directly downstream of the rotate primitives: it instantiates the fixed right-rotators (2, 6, 11, 13, 22, 25) to form Σ0 and Σ1. It consumes expanded message words W[t] from the upstream message-schedule stage over a valid/ready stream. It returns the chained 256-bit hash to the block sequencer.

## Interface
- No parameters; word width fixed at 32, round count fixed at 64.
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a block; sampled only in IDLE
- hin  in  256  chaining input; H0 in [255:224] … H7 in [31:0]
- w_valid  in  1  W word present
- w_data  in  32  W[t], delivered in order t=0..63
- w_ready  out  1  engine accepts a W word this cycle
- busy  out  1  block in progress
- done  out  1  one-cycle pulse, hout valid
- hout  out  256  updated hash, same word order as hin; holds until next done

## Operation
- States: IDLE, ROUND, FINAL.
- IDLE: busy=0, w_ready=0. On start=1:
  - latch hin into working regs a..h and into saved regs H0..H7;
  - t←0; go ROUND.
- ROUND: busy=1, w_ready=1. Each cycle with w_valid=1 (an accept):
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + w_data
  - T2 = Σ0(a) + Maj(a,b,c)
  - h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2; t←t+1.
  - Accept at t=63 → FINAL.
  - w_valid=0: registers and t hold (stall).
- Round functions:
  - Σ0 = ROTR2^ROTR13^ROTR22
  - Σ1 = ROTR6^ROTR11^ROTR25
  - Ch = (e&f)^(~e&g)
  - Maj = (a&b)^(a&c)^(b&c)
- K[0..63]: FIPS 180-4 constants, combinational ROM indexed by the 6-bit t.
- All additions are modulo 2^32; carries are discarded.
- FINAL: hout word i ← Hi + working word i (mod 2^32); done=1 for this cycle; busy=1; go IDLE.
- start is ignored outside IDLE. w_data is ignored outside accepts.
- Reset: all registers clear asynchronously; state IDLE.
  - Reset values: w_ready=0, busy=0, done=0, hout=0.
  - Mid-block reset abandons the block; no partial done.

## Timing
- Start accepted at edge 0 → ROUND from cycle 1.
- With w_valid held high: accepts occur in cycles 1..64, FINAL and done in cycle 65, IDLE in cycle 66.
- Each stall cycle adds exactly one cycle to the latency.
- A new start is accepted in the IDLE cycle that follows done. The minimum block-to-block period is 66 cycles.
- w_ready is a registered function of state, with no combinational path from w_valid.
- hout and done are registered. hout changes only on the edge that raises done.

## Test plan
- "abc" block:
  - stimulus: hin = IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19); W from the bench schedule model (W0=61626380, W15=00000018); w_valid constant.
  - required: done in cycle 65; hout = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Round-0 probe on the same stimulus: after the first accept, a=5d6aebcd and e=fa2a4622 (hierarchical peek).
- Stalls: same block with pseudo-random w_valid gaps (~30% low).
  - required: identical digest; done latency = 65 + gap count; exactly 64 accepts.
- start while busy:
  - stimulus: pulse start with a different hin at round 10.
  - required: ignored; digest unchanged; a single done.
- Reset mid-block:
  - stimulus: assert rst_n low at round 30.
  - required: busy, w_ready, done, hout all 0 immediately.
  - then run "abc" afterwards; required: the correct digest.
- Two-block chaining: "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq".
  - stimulus: block 2 uses hin = block-1 hout; start issued the cycle after done.
  - required: final hout = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
